// File: rtl/cfg_membank_loader.sv
// Configuration-memory bank programmer: assembles one bit-line row per word line from a
// word-serial stream, then fires a timed one-hot word-line pulse while BL is held stable.
module cfg_membank_loader #(
    parameter int BL_WIDTH     = 315,
    parameter int WL_WIDTH     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    input  logic                  cfg_last,
    output logic                  cfg_ready,
    output logic [BL_WIDTH-1:0]   bl_out,
    output logic [WL_WIDTH-1:0]   wl_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int WPR    = (BL_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int WORD_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int ROW_W  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        PULSE,
        HOLD,
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] word;
    logic [ROW_W-1:0]  row;
    logic [3:0]        timer;
    logic              last_seen;

    logic              word_end;
    logic              row_end;
    logic              final_word;
    logic [31:0]       shamt;
    logic [BL_WIDTH-1:0] slice_mask;
    logic [BL_WIDTH-1:0] slice_data;

    assign word_end   = (word == WORD_W'(WPR - 1));
    assign row_end    = (row == ROW_W'(WL_WIDTH - 1));
    assign final_word = word_end && row_end;

    // Bits of the last word that fall beyond BL_WIDTH are shifted out and simply vanish.
    assign shamt      = 32'(word) * 32'(DATA_WIDTH);
    assign slice_mask = BL_WIDTH'({DATA_WIDTH{1'b1}}) << shamt;
    assign slice_data = BL_WIDTH'(cfg_data) << shamt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bl_out    <= '0;
            wl_out    <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            row       <= '0;
            word      <= '0;
            timer     <= '0;
            last_seen <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LOAD;
                        bl_out    <= '0;
                        row       <= '0;
                        word      <= '0;
                        last_seen <= 1'b0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_valid && cfg_ready) begin
                        bl_out <= (bl_out & ~slice_mask) | (slice_data & slice_mask);
                        if (cfg_last && !final_word) begin
                            state     <= ERR;
                            word      <= '0;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                        end else if (word_end) begin
                            state     <= SETUP;
                            word      <= '0;
                            cfg_ready <= 1'b0;
                            timer     <= 4'(SETUP_CYCLES - 1);
                            last_seen <= cfg_last;
                        end else begin
                            word <= word + 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (timer == 4'd0) begin
                        state  <= PULSE;
                        wl_out <= WL_WIDTH'(1) << row;
                        timer  <= 4'(PULSE_CYCLES - 1);
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                PULSE: begin
                    if (timer == 4'd0) begin
                        state  <= HOLD;
                        wl_out <= '0;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                HOLD: begin
                    // The last row's outcome depends on whether the stream was properly terminated.
                    if (row_end) begin
                        busy <= 1'b0;
                        if (last_seen) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end else begin
                        state     <= LOAD;
                        row       <= row + 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wl_out    <= '0;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_membank_loader.sv
// Directed bench for cfg_membank_loader: checkpoint table for the nominal bank write plus
// hand-written runs for backpressure, truncation, early/missing last and reset mid-pulse.
module tb_cfg_membank_loader;

    localparam int BLW = 315;
    localparam int WLW = 4;
    localparam int DW  = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [DW-1:0]  cfg_data = '0;
    logic           cfg_valid = 1'b0;
    logic           cfg_last = 1'b0;
    logic           cfg_ready;
    logic [BLW-1:0] bl_out;
    logic [WLW-1:0] wl_out;
    logic           busy;
    logic           done;
    logic           error;

    cfg_membank_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_last  (cfg_last),
        .cfg_ready (cfg_ready),
        .bl_out    (bl_out),
        .wl_out    (wl_out),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        int          t;
        logic [3:0]  wl;
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic        er;
        logic        chk_bl;
        logic [31:0] bl_lo;
    } chk_t;

    chk_t tbl[17];

    int             pcnt[4];
    logic [BLW-1:0] pbl[4];
    int             setup_ok[4];
    int             rdy_bad;
    int             multihot;
    int             nacc;
    int             t_end;
    logic           fin_done, fin_err, fin_busy;
    logic [3:0]     fin_wl;

    task automatic check_vec(input string name, input logic [BLW-1:0] act, input logic [BLW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wval(input int n, input bit trunc);
        if (trunc && n == 39) return 32'hFFFF_FFFF;
        return 32'hA5A5_0000 + 32'(n);
    endfunction

    // Expected full BL row built bit by bit from the stream words of that row.
    function automatic logic [BLW-1:0] exp_row(input int r, input bit trunc);
        logic [BLW-1:0] v;
        logic [31:0]    w;
        v = '0;
        for (int k = 0; k < 10; k++) begin
            w = wval(10 * r + k, trunc);
            for (int j = 0; j < DW; j++)
                if (k * DW + j < BLW) v[k * DW + j] = w[j];
        end
        return v;
    endfunction

    task automatic run(input int nwords, input int last_idx, input bit gaps, input bit trunc,
                       input bit use_tbl, input int abort_row);
        int             n;
        logic           acc;
        logic [3:0]     pwl;
        logic           prdy;
        logic [BLW-1:0] pbl_prev;
        for (int r = 0; r < 4; r++) begin
            pcnt[r] = 0; pbl[r] = '0; setup_ok[r] = 0;
        end
        rdy_bad = 0; multihot = 0; t_end = -1;
        @(negedge clk);
        start = 1'b1; cfg_valid = 1'b0; cfg_last = 1'b0;
        @(posedge clk);
        n = 0; pwl = 4'h0; prdy = 1'b1; pbl_prev = '0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (use_tbl)
                foreach (tbl[i])
                    if (tbl[i].t == t)
                        check_vec($sformatf("nominal_t%0d", t),
                                  BLW'({wl_out, cfg_ready, busy, done, error,
                                        (tbl[i].chk_bl ? bl_out[31:0] : 32'h0)}),
                                  BLW'({tbl[i].wl, tbl[i].rdy, tbl[i].bsy, tbl[i].dn, tbl[i].er,
                                        tbl[i].bl_lo}));
            if (wl_out != 4'h0) begin
                if ($countones(wl_out) != 1) multihot++;
                else
                    for (int r = 0; r < 4; r++)
                        if (wl_out == (4'(1) << r)) begin
                            if (pwl == 4'h0) begin
                                pbl[r] = bl_out;
                                if (!prdy && pbl_prev == bl_out) setup_ok[r] = 1;
                            end
                            pcnt[r]++;
                        end
                if (cfg_ready) rdy_bad++;
                if (abort_row >= 0 && wl_out == (4'(1) << abort_row) && pcnt[abort_row] == 2) begin
                    reset = 1'b0;
                    t_end = t;
                    break;
                end
            end else if (pwl != 4'h0 && cfg_ready) begin
                rdy_bad++;
            end
            if (done || error) begin
                t_end = t;
                break;
            end
            pwl = wl_out; prdy = cfg_ready; pbl_prev = bl_out;
            if (gaps && t == 30) start = 1'b1;
            if (n < nwords && (!gaps || (t % 2) == 1)) begin
                cfg_valid = 1'b1;
                cfg_data  = wval(n, trunc);
                cfg_last  = (n == last_idx);
            end else begin
                cfg_valid = 1'b0;
                cfg_data  = 32'hDEAD_0000 | 32'(t);
                cfg_last  = ((t % 2) == 0);
            end
            acc = cfg_valid && cfg_ready;
            @(posedge clk);
            if (acc) n++;
        end
        cfg_valid = 1'b0; cfg_last = 1'b0; start = 1'b0;
        nacc = n;
        fin_done = done; fin_err = error; fin_busy = busy; fin_wl = wl_out;
        check_int("run_within_budget", int'(t_end >= 0), 1);
    endtask

    task automatic post(input string nm, input bit trunc);
        for (int r = 0; r < 4; r++) begin
            check_int($sformatf("%s_pulse_len_r%0d", nm, r), pcnt[r], 2);
            check_vec($sformatf("%s_bl_r%0d", nm, r), pbl[r], exp_row(r, trunc));
            check_int($sformatf("%s_setup_r%0d", nm, r), setup_ok[r], 1);
        end
        check_int({nm, "_multihot"}, multihot, 0);
        check_int({nm, "_ready_outside_load"}, rdy_bad, 0);
        check_int({nm, "_words_taken"}, nacc, 40);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,  4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{5,  4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0000};
        tbl[2]  = '{10, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0000};
        tbl[3]  = '{11, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0000};
        tbl[4]  = '{12, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{13, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{14, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{24, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_000A};
        tbl[8]  = '{25, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_000A};
        tbl[9]  = '{26, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{27, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{39, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0014};
        tbl[12] = '{40, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{53, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_001E};
        tbl[14] = '{54, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[15] = '{55, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[16] = '{56, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("reset_flags", BLW'({wl_out, cfg_ready, busy, done, error}), '0);
        check_vec("reset_bl", bl_out, '0);
        reset = 1'b1;

        run(40, 39, 1'b0, 1'b0, 1'b1, -1);
        post("nominal", 1'b0);
        check_int("nominal_done_cycle", t_end, 56);
        check_vec("nominal_end_flags", BLW'({fin_done, fin_err, fin_busy, fin_wl}), BLW'(7'b1000000));
        repeat (3) @(negedge clk);
        check_vec("done_sticky", BLW'({done, error, busy, wl_out}), BLW'(7'b1000000));
        check_vec("done_bl_held", bl_out, exp_row(3, 1'b0));

        run(40, 39, 1'b1, 1'b0, 1'b0, -1);
        post("backpressure", 1'b0);
        check_vec("backpressure_end_flags", BLW'({fin_done, fin_err, fin_busy}), BLW'(3'b100));

        run(40, 39, 1'b0, 1'b1, 1'b0, -1);
        post("truncation", 1'b1);
        check_vec("truncation_top27", BLW'(pbl[3][314:288]), BLW'(27'h7FF_FFFF));
        check_int("truncation_done", int'(fin_done), 1);

        run(40, 15, 1'b0, 1'b0, 1'b0, -1);
        check_vec("early_last_flags", BLW'({fin_err, fin_busy, fin_done, fin_wl}), BLW'(7'b1000000));
        check_int("early_last_cycle", t_end, 20);
        check_int("early_last_row0_pulses", pcnt[0], 2);
        check_int("early_last_row1_pulses", pcnt[1], 0);
        check_int("early_last_words", nacc, 16);

        run(40, -1, 1'b0, 1'b0, 1'b0, -1);
        post("missing_last", 1'b0);
        check_vec("missing_last_flags", BLW'({fin_err, fin_done, fin_busy}), BLW'(3'b100));
        check_int("missing_last_cycle", t_end, 56);

        run(40, 39, 1'b0, 1'b0, 1'b0, -1);
        post("recovery", 1'b0);
        check_vec("recovery_flags", BLW'({fin_done, fin_err}), BLW'(2'b10));

        run(40, 39, 1'b0, 1'b0, 1'b0, 1);
        check_int("abort_cycle", t_end, 26);
        @(posedge clk);
        @(negedge clk);
        check_vec("abort_flags", BLW'({wl_out, cfg_ready, busy, done, error}), '0);
        check_vec("abort_bl", bl_out, '0);
        reset = 1'b1;
        @(negedge clk);
        check_vec("abort_stays_idle", BLW'({cfg_ready, busy, done, error}), '0);

        run(40, 39, 1'b0, 1'b0, 1'b0, -1);
        post("after_reset", 1'b0);
        check_vec("after_reset_flags", BLW'({fin_done, fin_err}), BLW'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
